// File: rtl/hci_reorder_seq_pkg.sv
// Shared types for the reorder-router burst sequencer.
// Holds the FSM state encoding and the per-lane address helper.
package hci_reorder_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } hci_reorder_seq_state_e;

  // Word address of a lane inside the current beat; wraps modulo 2^32.
  function automatic logic [31:0] lane_addr(input logic [31:0] base, input int unsigned lane);
    return base + 32'(lane * 4);
  endfunction

endpackage

// File: rtl/hci_reorder_seq_if.sv
// Request/response bundle between the sequencer and router input channel 0.
// The sequencer is the master; the router side is the slave.
interface hci_reorder_seq_if #(
  parameter int unsigned NB_IN_CHAN  = 2,
  parameter int unsigned NB_OUT_CHAN = 2
) ();

  localparam int unsigned ORD_W = (NB_OUT_CHAN > 1) ? $clog2(NB_OUT_CHAN) : 1;

  logic                         req;
  logic                         gnt;
  logic                         r_valid;
  logic                         wen;
  logic [ORD_W-1:0]             order;
  logic [NB_IN_CHAN-1:0][31:0]  addr;
  logic [NB_IN_CHAN-1:0]        lane_en;

  modport master (
    output req, wen, order, addr, lane_en,
    input  gnt, r_valid
  );

  modport slave (
    input  req, wen, order, addr, lane_en,
    output gnt, r_valid
  );

endinterface

// File: rtl/hci_reorder_seq.sv
// Burst sequencer: walks a word-aligned address range beat by beat into
// hci_router_reorder and reports completion after the last response.
module hci_reorder_seq
  import hci_reorder_seq_pkg::*;
#(
  parameter int unsigned NB_IN_CHAN           = 2,
  parameter int unsigned NB_OUT_CHAN          = 2,
  parameter int unsigned LEN_W                = 16,
  parameter int unsigned FILTER_WRITE_R_VALID = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic                wen_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [LEN_W-1:0]    beats_left_o,
  hci_reorder_seq_if.master   rtr_if
);

  localparam int unsigned      ORD_W     = (NB_OUT_CHAN > 1) ? $clog2(NB_OUT_CHAN) : 1;
  localparam logic [31:0]      ADDR_STEP = 32'(4 * NB_IN_CHAN);
  localparam logic [LEN_W-1:0] LANES     = LEN_W'(NB_IN_CHAN);
  localparam logic [LEN_W:0]   LANES_X   = (LEN_W + 1)'(NB_IN_CHAN);
  localparam logic             FILT_WR   = (FILTER_WRITE_R_VALID != 0);

  hci_reorder_seq_state_e state_q, state_d;
  logic [31:0]            cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]       rem_words_q, rem_words_d;
  logic                   wen_q, wen_d;
  logic                   zero_done_q, zero_done_d;

  logic                   run;
  logic                   handshake;
  logic                   last_beat;
  logic                   drain_exit;
  logic [LEN_W:0]         rem_round;
  logic [LEN_W:0]         beats_full;

  assign run        = (state_q == SEQ_RUN);
  assign handshake  = run & rtr_if.gnt;
  assign last_beat  = (rem_words_q <= LANES);
  // Filtered writes never see r_valid, so DRAIN only lasts its single cycle.
  assign drain_exit = (state_q == SEQ_DRAIN) & (rtr_if.r_valid | (~wen_q & FILT_WR));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q     <= SEQ_IDLE;
      cur_addr_q  <= '0;
      rem_words_q <= '0;
      wen_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_words_q <= rem_words_d;
      wen_q       <= wen_d;
      zero_done_q <= zero_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_words_d = rem_words_q;
    wen_d       = wen_q;
    zero_done_d = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cur_addr_d  = {base_addr_i[31:2], 2'b00};
            rem_words_d = len_i;
            wen_d       = wen_i;
            state_d     = SEQ_RUN;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (handshake) begin
          cur_addr_d  = cur_addr_q + ADDR_STEP;
          rem_words_d = last_beat ? '0 : (rem_words_q - LANES);
          if (last_beat) begin
            state_d = SEQ_DRAIN;
          end
        end
      end
      SEQ_DRAIN: begin
        if (drain_exit) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // The completion pulse is suppressed in any cycle where a clear or reset wins.
  assign done_o  = (zero_done_q | drain_exit) & ~clear_i & rst_ni;
  assign ready_o = (state_q == SEQ_IDLE) | done_o;
  assign busy_o  = (state_q == SEQ_RUN) | (state_q == SEQ_DRAIN);

  assign rem_round    = {1'b0, rem_words_q} + (LANES_X - 1'b1);
  assign beats_full   = rem_round / LANES_X;
  assign beats_left_o = beats_full[LEN_W-1:0];

  assign rtr_if.req   = run;
  assign rtr_if.wen   = wen_q;
  assign rtr_if.order = run ? cur_addr_q[2 +: ORD_W] : '0;

  for (genvar gi = 0; gi < NB_IN_CHAN; gi++) begin : g_lane
    assign rtr_if.addr[gi]    = run ? lane_addr(cur_addr_q, gi) : 32'h0;
    assign rtr_if.lane_en[gi] = run & (rem_words_q > LEN_W'(gi));
  end

endmodule

// File: tb/tb_hci_reorder_seq.sv
// Directed bench for hci_reorder_seq with a latency-1 router response model.
module tb_hci_reorder_seq;

  localparam int unsigned NI = 2;
  localparam int unsigned NO = 4;
  localparam int unsigned LW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          wen   = 1'b0;
  logic [31:0]   base  = '0;
  logic [LW-1:0] len   = '0;
  logic          ready, busy, done;
  logic [LW-1:0] beats_left;

  int checks = 0;
  int errors = 0;

  hci_reorder_seq_if #(.NB_IN_CHAN(NI), .NB_OUT_CHAN(NO)) ifc ();

  hci_reorder_seq #(
    .NB_IN_CHAN(NI), .NB_OUT_CHAN(NO), .LEN_W(LW), .FILTER_WRITE_R_VALID(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .base_addr_i(base), .len_i(len), .wen_i(wen),
    .ready_o(ready), .busy_o(busy), .done_o(done), .beats_left_o(beats_left),
    .rtr_if(ifc)
  );

  always #5 clk = ~clk;

  // Router model: reads answer one cycle after the handshake, filtered writes never do.
  always @(posedge clk) ifc.r_valid <= rst_n & ifc.req & ifc.gnt & ifc.wen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] b, input logic [LW-1:0] l, input logic w);
    base  = b;
    len   = l;
    wen   = w;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] ord, input logic [1:0] le, input logic [LW-1:0] bl);
    chk({tag, ".req"},   64'(ifc.req), 64'd1);
    chk({tag, ".a0"},    64'(ifc.addr[0]), 64'(a0));
    chk({tag, ".a1"},    64'(ifc.addr[1]), 64'(a1));
    chk({tag, ".order"}, 64'(ifc.order), 64'(ord));
    chk({tag, ".lane"},  64'(ifc.lane_en), 64'(le));
    chk({tag, ".beats"}, 64'(beats_left), 64'(bl));
    chk({tag, ".done"},  64'(done), 64'd0);
  endtask

  initial begin
    ifc.gnt = 1'b1;
    repeat (3) step();
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.done",  64'(done), 64'd0);
    chk("rst.req",   64'(ifc.req), 64'd0);
    chk("rst.wen",   64'(ifc.wen), 64'd0);
    chk("rst.order", 64'(ifc.order), 64'd0);
    chk("rst.addr",  64'(ifc.addr), 64'd0);
    chk("rst.lane",  64'(ifc.lane_en), 64'd0);
    chk("rst.beats", 64'(beats_left), 64'd0);
    rst_n = 1'b1;
    step();

    // Read burst of 5 words, grant always high; a start while busy is ignored.
    launch(32'h100, 16'd5, 1'b1);
    beat("rd0", 32'h100, 32'h104, 2'd0, 2'b11, 16'd3);
    chk("rd0.wen",   64'(ifc.wen), 64'd1);
    chk("rd0.busy",  64'(busy), 64'd1);
    chk("rd0.ready", 64'(ready), 64'd0);
    start = 1'b1;
    len   = 16'd0;
    step();
    start = 1'b0;
    beat("rd1", 32'h108, 32'h10C, 2'd2, 2'b11, 16'd2);
    step();
    beat("rd2", 32'h110, 32'h114, 2'd0, 2'b01, 16'd1);
    step();
    chk("rd.c4.req",   64'(ifc.req), 64'd0);
    chk("rd.c4.done",  64'(done), 64'd1);
    chk("rd.c4.ready", 64'(ready), 64'd1);
    step();
    chk("rd.c5.done",  64'(done), 64'd0);
    chk("rd.c5.busy",  64'(busy), 64'd0);
    chk("rd.c5.ready", 64'(ready), 64'd1);

    // Same burst with a two-cycle grant stall on the second beat.
    launch(32'h100, 16'd5, 1'b1);
    beat("st0", 32'h100, 32'h104, 2'd0, 2'b11, 16'd3);
    step();
    ifc.gnt = 1'b0;
    beat("st1a", 32'h108, 32'h10C, 2'd2, 2'b11, 16'd2);
    step();
    beat("st1b", 32'h108, 32'h10C, 2'd2, 2'b11, 16'd2);
    step();
    ifc.gnt = 1'b1;
    beat("st1c", 32'h108, 32'h10C, 2'd2, 2'b11, 16'd2);
    step();
    beat("st2", 32'h110, 32'h114, 2'd0, 2'b01, 16'd1);
    step();
    chk("st.c6.done", 64'(done), 64'd1);
    step();
    chk("st.c7.done", 64'(done), 64'd0);

    // Unaligned base with address wrap.
    launch(32'hFFFF_FFFA, 16'd3, 1'b1);
    beat("wr0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 2'd2, 2'b11, 16'd2);
    step();
    beat("wr1", 32'h0000_0000, 32'h0000_0004, 2'd0, 2'b01, 16'd1);
    step();
    chk("wr.c3.done", 64'(done), 64'd1);
    step();
    chk("wr.c4.done", 64'(done), 64'd0);

    // Zero length: done only, then the same with clear in the done cycle.
    launch(32'h300, 16'd0, 1'b1);
    chk("z.req",   64'(ifc.req), 64'd0);
    chk("z.done",  64'(done), 64'd1);
    chk("z.ready", 64'(ready), 64'd1);
    chk("z.busy",  64'(busy), 64'd0);
    step();
    chk("z.c2.done", 64'(done), 64'd0);
    launch(32'h300, 16'd0, 1'b1);
    clear = 1'b1;
    #1;
    chk("zc.done", 64'(done), 64'd0);
    step();
    clear = 1'b0;
    #1;
    chk("zc.c2.done",  64'(done), 64'd0);
    chk("zc.c2.ready", 64'(ready), 64'd1);

    // Filtered write: no r_valid, done one cycle after the only handshake.
    step();
    launch(32'h200, 16'd2, 1'b0);
    beat("fw0", 32'h200, 32'h204, 2'd0, 2'b11, 16'd1);
    chk("fw0.wen", 64'(ifc.wen), 64'd0);
    step();
    chk("fw.c2.rvalid", 64'(ifc.r_valid), 64'd0);
    chk("fw.c2.req",    64'(ifc.req), 64'd0);
    chk("fw.c2.done",   64'(done), 64'd1);
    step();
    chk("fw.c3.done",  64'(done), 64'd0);
    chk("fw.c3.ready", 64'(ready), 64'd1);

    // Clear during the second beat, then a fresh burst.
    launch(32'h100, 16'd5, 1'b1);
    beat("cl0", 32'h100, 32'h104, 2'd0, 2'b11, 16'd3);
    step();
    clear = 1'b1;
    #1;
    beat("cl1", 32'h108, 32'h10C, 2'd2, 2'b11, 16'd2);
    step();
    clear = 1'b0;
    #1;
    chk("cl.c3.req",   64'(ifc.req), 64'd0);
    chk("cl.c3.ready", 64'(ready), 64'd1);
    chk("cl.c3.busy",  64'(busy), 64'd0);
    chk("cl.c3.done",  64'(done), 64'd0);
    chk("cl.c3.beats", 64'(beats_left), 64'd0);
    chk("cl.c3.lane",  64'(ifc.lane_en), 64'd0);
    step();
    chk("cl.c4.done", 64'(done), 64'd0);
    launch(32'h48, 16'd2, 1'b1);
    beat("nw0", 32'h48, 32'h4C, 2'd2, 2'b11, 16'd1);
    step();
    chk("nw.c2.done", 64'(done), 64'd1);
    step();
    chk("nw.c3.done", 64'(done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
